// File: rtl/div_pkg.sv
// Shared constants and state encodings for the iterative divider.
// Optional feature macro: DIV_ZERO_FAST_EN (short-circuits a zero divisor via BYZERO).
package div_pkg;

  localparam int          DoubleRegBus      = 64;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;
  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
`ifdef DIV_ZERO_FAST_EN
    DivByZero = 2'b01,
`endif
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;

  // Magnitude of a two's-complement operand when signed mode is on.
  function automatic logic [31:0] div_mag(input logic is_signed, input logic [31:0] v);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_if.sv
// Request/result bundle between a requester and the divider.
// Handshake: the requester raises start_i with stable operands and keeps it
// high until it sees ready_o; operands are captured on the first edge that
// start_i is seen in FREE. result_o is meaningful only while ready_o is high,
// and stays frozen until start_i drops. annul_i aborts any operation at once.
interface div_if;
  import div_pkg::*;

  logic                    signed_div_i;
  logic [31:0]             opdata1_i;
  logic [31:0]             opdata2_i;
  logic                    start_i;
  logic                    annul_i;
  logic [DoubleRegBus-1:0] result_o;
  logic                    ready_o;
  div_state_t              state;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, state
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, state
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor in 33 bits, keep or restore.
module div_step
  import div_pkg::*;
(
  input  logic [31:0] rem,
  input  logic        dvd_bit,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic        q_bit
);

  logic [32:0] trial;

  // Partial remainder is always below the divisor, so the shifted value is
  // below twice the divisor and the 33-bit difference MSB is a clean borrow.
  always_comb begin
    trial    = {rem, dvd_bit} - {1'b0, divisor};
    q_bit    = ~trial[32];
    rem_next = trial[32] ? {rem[30:0], dvd_bit} : trial[31:0];
  end

endmodule

// File: rtl/div.sv
// 32-bit signed/unsigned restoring divider, one quotient bit per cycle.
// Optional feature macro: DIV_ZERO_FAST_EN (zero divisor answers 0 in 2 cycles).
module div
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  div_state_t              state_q, state_d;
  logic [5:0]              cnt_q;
  logic [31:0]             divisor_q;
  logic [31:0]             rem_q;
  logic [31:0]             dq_q;
  logic                    neg_q_q;
  logic                    neg_r_q;
  logic [DoubleRegBus-1:0] result_q;
  logic                    ready_q;

  logic        accept;
  logic [31:0] rem_next;
  logic        q_bit;
  logic [31:0] quo_raw;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // dq_q starts as the dividend magnitude; its MSB feeds each step while the
  // new quotient bit enters at the bottom, so after 32 steps it holds the quotient.
  div_step u_step (
    .rem      (rem_q),
    .dvd_bit  (dq_q[31]),
    .divisor  (divisor_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign accept = (bus.start_i == DivStart) && !bus.annul_i;

  // Final quotient/remainder with sign restored; negation wraps modulo 2^32.
  always_comb begin
    quo_raw = {dq_q[30:0], q_bit};
    quo_fix = neg_q_q ? (~quo_raw + 32'd1) : quo_raw;
    rem_fix = neg_r_q ? (~rem_next + 32'd1) : rem_next;
  end

  // Next-state selection; annul overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (bus.annul_i) begin
      state_d = DivFree;
    end else begin
      case (state_q)
        DivFree: begin
          if (bus.start_i == DivStart) begin
`ifdef DIV_ZERO_FAST_EN
            state_d = (bus.opdata2_i == ZeroWord) ? DivByZero : DivOn;
`else
            state_d = DivOn;
`endif
          end
        end
`ifdef DIV_ZERO_FAST_EN
        DivByZero: state_d = DivEnd;
`endif
        DivOn:   state_d = (cnt_q == 6'd31) ? DivEnd : DivOn;
        DivEnd:  state_d = (bus.start_i == DivStop) ? DivFree : DivEnd;
        default: state_d = DivFree;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= DivFree;
    else     state_q <= state_d;
  end

  // Operand capture, iteration datapath and registered result/ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 6'd0;
      divisor_q <= ZeroWord;
      rem_q     <= ZeroWord;
      dq_q      <= ZeroWord;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      if (state_q == DivFree && accept) begin
        divisor_q <= div_mag(bus.signed_div_i, bus.opdata2_i);
        dq_q      <= div_mag(bus.signed_div_i, bus.opdata1_i);
        rem_q     <= ZeroWord;
        cnt_q     <= 6'd0;
        neg_q_q   <= bus.signed_div_i && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
        neg_r_q   <= bus.signed_div_i && bus.opdata1_i[31];
      end
      if (state_q == DivOn) begin
        rem_q <= rem_next;
        dq_q  <= quo_raw;
        cnt_q <= cnt_q + 6'd1;
        if (state_d == DivEnd) begin
          result_q <= {rem_fix, quo_fix};
          ready_q  <= DivResultReady;
        end
      end
`ifdef DIV_ZERO_FAST_EN
      if (state_q == DivByZero && state_d == DivEnd) begin
        result_q <= '0;
        ready_q  <= DivResultReady;
      end
`endif
      if (state_d == DivFree) begin
        result_q <= '0;
        ready_q  <= DivResultNotReady;
      end
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.state    = state_q;

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have port `clk`: input, 1 bit, the only clock; all state updates on its rising edge.
REQ-002 The block SHALL have port `rst`: input, 1 bit, synchronous, active-high reset.
REQ-003 The block SHALL have port `signed_div_i`: input, 1 bit, 1 = two's-complement divide, 0 = unsigned.
REQ-004 The block SHALL have port `opdata1_i`: input, 32 bits, dividend.
REQ-005 The block SHALL have port `opdata2_i`: input, 32 bits, divisor.
REQ-006 The block SHALL have port `start_i`: input, 1 bit, DivStart request; the requester holds it high until it sees `ready_o`.
REQ-007 The block SHALL have port `annul_i`: input, 1 bit, cancels any operation in progress.
REQ-008 The block SHALL have port `result_o`: output, 64 bits, `{remainder[63:32], quotient[31:0]}`, valid only while `ready_o`=1.
REQ-009 The block SHALL have port `ready_o`: output, 1 bit, DivResultReady.

Function
REQ-010 The state machine SHALL have four states: FREE, BYZERO, ON, END.
REQ-011 In FREE with `start_i`=1 and `annul_i`=0, the block SHALL latch operands and sign mode at that edge; later operand changes SHALL be ignored until the next return to FREE.
REQ-012 When latching a signed operation, each negative operand SHALL be replaced by its two's-complement magnitude; unsigned operands SHALL be taken as-is.
REQ-013 From FREE on start with a nonzero divisor, the next state SHALL be ON with a 6-bit iteration counter cleared to 0.
REQ-014 In ON, each cycle SHALL perform one restoring step: a 33-bit trial subtraction of the divisor from the partial remainder, with the result bit shifted into the quotient. The counter SHALL increment by 1.
REQ-015 After exactly 32 ON cycles, the block SHALL enter END.
REQ-016 On entering END, `result_o` SHALL be registered with sign fix-up:
- Quotient negated if the signed operation's operand signs differ.
- Remainder negated if the signed dividend was negative.
- Overflow wraps modulo 2^32.
REQ-017 On entering END, `ready_o` SHALL be set to 1.
REQ-018 Latency SHALL be 33 cycles: `ready_o` first reads 1 in the 33rd cycle after the edge at which `start_i` was sampled in FREE.
REQ-019 In END, `ready_o` and `result_o` SHALL hold steady while `start_i`=1.
REQ-020 In END with `start_i`=0, the next state SHALL be FREE with `ready_o`=0 and `result_o`=0. There SHALL be no back-to-back restart in that same edge.
REQ-021 When `annul_i`=1 in BYZERO, ON or END, the block SHALL move to FREE next edge with `ready_o`=0 and `result_o`=0.
REQ-022 `annul_i` SHALL take priority over all other transitions, including a simultaneous 32nd iteration.
REQ-023 In FREE, `annul_i`=1 SHALL block the start from being accepted that cycle.
REQ-024 `start_i` deasserted during ON SHALL NOT abort the operation; only `annul_i` aborts.

Reset
REQ-025 When `rst`=1 at a clock edge, the state SHALL go to FREE and the counter to 0.
REQ-026 When `rst`=1 at a clock edge, `ready_o` SHALL go to 0 and `result_o` to 0.
REQ-027 Reset SHALL take priority over `annul_i`, `start_i` and any in-flight operation.
REQ-028 The first start SHALL be accepted on the first edge with `rst`=0.

Configuration
REQ-029 Macro `DIV_ZERO_FAST_EN` SHALL select divide-by-zero handling.
REQ-030 With `DIV_ZERO_FAST_EN` defined, a zero divisor latched in FREE SHALL route to BYZERO.
REQ-031 BYZERO SHALL go to END on the next edge with `result_o`=0 and `ready_o`=1 (2-cycle latency).
REQ-032 Without `DIV_ZERO_FAST_EN`, the BYZERO state and logic SHALL be absent.
REQ-033 Without `DIV_ZERO_FAST_EN`, a zero divisor SHALL run the full 32 iterations. The raw unsigned result SHALL be quotient 0xFFFFFFFF, remainder = dividend magnitude, followed by the normal sign fix-up.

Structure
REQ-034 State encodings SHALL be named constants in the shared defines header: DivFree, DivByZero, DivOn, DivEnd.
REQ-035 Handshake levels DivStart/DivStop and DivResultReady/DivResultNotReady SHALL be named constants in the shared defines header.
REQ-036 ZeroWord and DoubleRegBus SHALL be named constants in the shared defines header.
REQ-037 The block SHALL contain one combinational sub-module, `div_step`: 33-bit trial subtract plus quotient-bit select.

Verification
REQ-038 Unsigned 100 / 7 SHALL give `ready_o`=1 at cycle 33 with `result_o` = `{32'd2, 32'd14}`.
REQ-039 Signed -7 / 2 (0xFFFFFFF9 / 0x2) SHALL give quotient 0xFFFFFFFD and remainder 0xFFFFFFFF.
REQ-040 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0x00000000 (wrap, no trap).
REQ-041 Divisor 0 with `DIV_ZERO_FAST_EN` SHALL give `ready_o`=1 at cycle 2 with `result_o`=0.
REQ-042 Divisor 0 without `DIV_ZERO_FAST_EN` (unsigned 5 / 0) SHALL give quotient 0xFFFFFFFF and remainder 5 at cycle 33.
REQ-043 `annul_i` pulsed at ON cycle 10 SHALL give `ready_o`=0 throughout and state FREE next edge; a new 9 / 3 SHALL then return quotient 3, remainder 0 at cycle 33.
REQ-044 `start_i` held 5 cycles past `ready_o` SHALL leave `result_o` stable; after `start_i` drops, `ready_o`=0 on the next edge.
REQ-045 `rst` asserted mid-ON SHALL give `ready_o`=0 and `result_o`=0 next edge.
